// File: rtl/rob_mw.sv
// Multi-way reorder buffer: in-order dispatch, out-of-order writeback,
// in-order retire of up to RETIRE_W entries per cycle, flush on mispredict.
module rob_mw #(
  parameter int N_ENTRIES = 16,
  parameter int N_WB      = 3,
  parameter int N_RD      = 2,
  parameter int RETIRE_W  = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ARF_W     = 5,
  localparam int ID_W     = $clog2(N_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst_aL,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  output logic [ID_W-1:0]            dispatch_rob_id,
  input  logic                       dispatch_dst_valid,
  input  logic [ARF_W-1:0]           dispatch_dst_arf_id,
  input  logic [ADDR_W-1:0]          dispatch_pc,
  input  logic [N_WB-1:0]            wb_valid,
  input  logic [N_WB*ID_W-1:0]       wb_rob_id,
  input  logic [N_WB*DATA_W-1:0]     wb_reg_data,
  input  logic [N_WB-1:0]            wb_npc_valid,
  input  logic [N_WB*ADDR_W-1:0]     wb_npc,
  input  logic [N_WB-1:0]            wb_mispred,
  input  logic [N_RD*ID_W-1:0]       rd_rob_id,
  output logic [N_RD-1:0]            rd_ready,
  output logic [N_RD*DATA_W-1:0]     rd_data,
  output logic [RETIRE_W-1:0]        retire_valid,
  output logic [RETIRE_W-1:0]        retire_arf_we,
  output logic [RETIRE_W*ARF_W-1:0]  retire_arf_id,
  output logic [RETIRE_W*DATA_W-1:0] retire_reg_data,
  output logic                       redirect_valid,
  output logic [ADDR_W-1:0]          redirect_pc,
  output logic [ID_W:0]              count
);

  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(N_ENTRIES);

  logic [N_ENTRIES-1:0] valid_r;
  logic [N_ENTRIES-1:0] done_r;
  logic [N_ENTRIES-1:0] dst_valid_r;
  logic [N_ENTRIES-1:0] mispred_r;
  logic [ARF_W-1:0]     arf_id_r [N_ENTRIES];
  logic [ADDR_W-1:0]    pc_npc_r [N_ENTRIES];
  logic [DATA_W-1:0]    data_r   [N_ENTRIES];

  logic [ID_W-1:0] head_r;
  logic [ID_W-1:0] tail_r;
  logic [ID_W:0]   count_r;

  logic [ID_W-1:0] retire_idx_s [RETIRE_W];
  logic [ID_W:0]   n_ret_s;
  logic            dispatch_fire_s;

  assign count           = count_r;
  assign dispatch_rob_id = tail_r;
  assign dispatch_ready  = (count_r < FULL_CNT) && !redirect_valid;
  assign dispatch_fire_s = dispatch_valid && dispatch_ready;

  // Retire window: a slot retires only if every older slot retired and none mispredicted.
  always_comb begin
    logic chain_ok_s;
    chain_ok_s      = 1'b1;
    n_ret_s         = '0;
    retire_valid    = '0;
    retire_arf_we   = '0;
    retire_arf_id   = '0;
    retire_reg_data = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      retire_idx_s[k] = head_r + ID_W'(k);
      retire_arf_id[k*ARF_W +: ARF_W]     = arf_id_r[retire_idx_s[k]];
      retire_reg_data[k*DATA_W +: DATA_W] = data_r[retire_idx_s[k]];
      if (chain_ok_s && valid_r[retire_idx_s[k]] && done_r[retire_idx_s[k]]) begin
        retire_valid[k]  = 1'b1;
        retire_arf_we[k] = dst_valid_r[retire_idx_s[k]];
        n_ret_s          = n_ret_s + (ID_W+1)'(1);
        if (mispred_r[retire_idx_s[k]]) begin
          redirect_valid = 1'b1;
          redirect_pc    = pc_npc_r[retire_idx_s[k]];
          chain_ok_s     = 1'b0;
        end else begin
          chain_ok_s     = chain_ok_s;
        end
      end else begin
        chain_ok_s = 1'b0;
      end
    end
  end

  // Read ports see registered state only; no writeback bypass.
  always_comb begin
    logic [ID_W-1:0] rid_s;
    rd_ready = '0;
    rd_data  = '0;
    for (int r = 0; r < N_RD; r++) begin
      rid_s                       = rd_rob_id[r*ID_W +: ID_W];
      rd_ready[r]                 = valid_r[rid_s] & done_r[rid_s];
      rd_data[r*DATA_W +: DATA_W] = data_r[rid_s];
    end
  end

  // Entry state, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      valid_r     <= '0;
      done_r      <= '0;
      dst_valid_r <= '0;
      mispred_r   <= '0;
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        arf_id_r[i] <= '0;
        pc_npc_r[i] <= '0;
        data_r[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: in-flight writebacks and dispatch in this cycle are dropped.
      valid_r   <= '0;
      done_r    <= '0;
      mispred_r <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
    end else begin
      // Ascending port order makes the highest-indexed port win a same-id conflict.
      for (int p = 0; p < N_WB; p++) begin
        if (wb_valid[p] && valid_r[wb_rob_id[p*ID_W +: ID_W]]) begin
          done_r[wb_rob_id[p*ID_W +: ID_W]] <= 1'b1;
          data_r[wb_rob_id[p*ID_W +: ID_W]] <= wb_reg_data[p*DATA_W +: DATA_W];
          if (wb_npc_valid[p]) begin
            pc_npc_r[wb_rob_id[p*ID_W +: ID_W]]  <= wb_npc[p*ADDR_W +: ADDR_W];
            mispred_r[wb_rob_id[p*ID_W +: ID_W]] <= wb_mispred[p];
          end
        end
      end
      for (int k = 0; k < RETIRE_W; k++) begin
        if (retire_valid[k]) begin
          valid_r[retire_idx_s[k]] <= 1'b0;
        end
      end
      if (dispatch_fire_s) begin
        valid_r[tail_r]     <= 1'b1;
        done_r[tail_r]      <= 1'b0;
        dst_valid_r[tail_r] <= dispatch_dst_valid;
        arf_id_r[tail_r]    <= dispatch_dst_arf_id;
        pc_npc_r[tail_r]    <= dispatch_pc;
        mispred_r[tail_r]   <= 1'b0;
        data_r[tail_r]      <= '0;
      end
      head_r  <= head_r + n_ret_s[ID_W-1:0];
      tail_r  <= tail_r + ID_W'(dispatch_fire_s);
      count_r <= count_r + (ID_W+1)'(dispatch_fire_s) - n_ret_s;
    end
  end

endmodule

// File: doc/rob_mw.md
ROB_MW -- requirements
Module: rob_mw

Interface
REQ-001 Parameter N_ENTRIES, default 16, ROB depth; power of two, >= 4; ID_W = log2(N_ENTRIES).
REQ-002 Parameter N_WB, default 3, writeback port count, >= 1.
REQ-003 Parameter N_RD, default 2, register-read port count, >= 1.
REQ-004 Parameter RETIRE_W, default 2, retire slots per cycle, 1..4, <= N_ENTRIES.
REQ-005 Parameter DATA_W, default 32, register data width; ADDR_W, default 32, PC width; ARF_W, default 5.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_aL  in  1  asynchronous active-low reset.
REQ-008 dispatch_valid  in  1; dispatch_ready  out  1; dispatch_rob_id  out  ID_W  allocated tail id.
REQ-009 dispatch_dst_valid  in  1; dispatch_dst_arf_id  in  ARF_W; dispatch_pc  in  ADDR_W.
REQ-010 wb_valid  in  N_WB; wb_rob_id  in  N_WB*ID_W; wb_reg_data  in  N_WB*DATA_W.
REQ-011 wb_npc_valid  in  N_WB; wb_npc  in  N_WB*ADDR_W; wb_mispred  in  N_WB  per-port branch/load mispredict flag.
REQ-012 rd_rob_id  in  N_RD*ID_W; rd_ready  out  N_RD; rd_data  out  N_RD*DATA_W.
REQ-013 retire_valid  out  RETIRE_W; retire_arf_we  out  RETIRE_W; retire_arf_id  out  RETIRE_W*ARF_W; retire_reg_data  out  RETIRE_W*DATA_W.
REQ-014 redirect_valid  out  1; redirect_pc  out  ADDR_W; count  out  ID_W+1  occupied entries.

Function
REQ-015 Entry fields: valid, done, dst_valid, arf_id, pc_npc, mispred, data; head, tail pointers ID_W bits, wrap modulo N_ENTRIES.
REQ-016 dispatch_ready = (count < N_ENTRIES) and not redirect_valid; no retire-through when full.
REQ-017 dispatch_rob_id = tail, combinational; on valid&ready: entry[tail] <= {valid=1, done=0, dst fields, pc_npc=dispatch_pc, mispred=0, data=0}, tail++.
REQ-018 Writeback port p, if wb_valid[p] and entry valid: done<=1, data<=wb_reg_data[p]; if wb_npc_valid[p] also pc_npc<=wb_npc[p], mispred<=wb_mispred[p].
REQ-019 Writeback to an invalid entry is ignored.
REQ-020 Multiple ports same rob_id same cycle: highest port index wins all written fields.
REQ-021 Read port r combinational from registered state: rd_ready[r] = valid & done of entry; rd_data[r] = entry data; no same-cycle writeback bypass; invalid entry -> rd_ready 0.
REQ-022 Retire slot k (0..RETIRE_W-1) targets head+k; retire_valid[k] = entry valid & done & all slots j<k retire_valid & no slot j<k mispred.
REQ-023 retire_arf_we[k] = retire_valid[k] & dst_valid; retire_arf_id/retire_reg_data from entry; entries without destination still retire.
REQ-024 Retired entries cleared to valid=0 at edge; head advances by number of retire_valid bits set.
REQ-025 redirect_valid = any retire_valid[k] whose entry mispred=1; redirect_pc = that entry pc_npc; mispredicting instruction itself retires and writes ARF.
REQ-026 Flush: edge following redirect_valid clears all valid bits, head<=0, tail<=0, count<=0; same-cycle dispatch blocked (REQ-016), same-cycle writebacks discarded.
REQ-027 count = tail-head occupancy including full case, updated as count + dispatched - retired; never exceeds N_ENTRIES.
REQ-028 Retire, dispatch, writeback to distinct entries in one cycle all take effect.

Reset
REQ-029 While rst_aL low: all valid/done/mispred 0, head=tail=0, count=0, immediately, independent of clk.
REQ-030 Reset outputs: dispatch_ready=1, dispatch_rob_id=0, retire_valid=0, retire_arf_we=0, redirect_valid=0, count=0, rd_ready=0.
REQ-031 Reset asserted mid-operation discards all entries; first dispatch after release receives rob_id 0.

Verification
REQ-032 Fill: 16 dispatches, no wb -> ids 0..15, count=16, dispatch_ready=0; 17th dispatch_valid held, not accepted.
REQ-033 Dual retire: dispatch ids 0,1 (dst x5,x6), wb 0xA and 0xB -> next cycle retire_valid=2'b11, arf_id 5/6, data 0xA/0xB; head=2.
REQ-034 In-order block: wb id 1 only -> retire_valid=0 until id 0 written back, then both retire same cycle.
REQ-035 Mispredict flush: ids 0..3 valid, wb id 0 with npc 0x200 mispred=1, all done -> slot0 retires, slot1 0, redirect_valid=1, redirect_pc=0x200; next cycle count=0, next dispatch gets id 0.
REQ-036 Write conflict: ports 0 and 2 write id 3 with 0x11/0x22 same cycle -> rd_data for id 3 = 0x22; wb to empty id 7 leaves rd_ready 0.
REQ-037 Wrap: 20 dispatch/retire pairs with count held at 4 -> dispatch_rob_id wraps 15->0, no loss or duplication of retired data.
